// File: rtl/uart_cmd_parser_if.sv
// Byte-stream, status and response signals of the UART command parser.
// slave: the parser itself; master: whatever feeds bytes and takes responses.
interface uart_cmd_parser_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   cat_status;
  logic [127:0] key;
  logic         key_valid;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         frame_err;

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    output cat_status,
    output key,
    output key_valid,
    output tx_data,
    output tx_valid,
    output frame_err
  );

  modport master (
    output rx_data,
    output rx_valid,
    output tx_ready,
    input  cat_status,
    input  key,
    input  key_valid,
    input  tx_data,
    input  tx_valid,
    input  frame_err
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// UART command parser: validates framed commands from the receive byte stream,
// updates the cat status register and the AES key store, and answers each
// frame with a single ack/error/timeout byte through a one-entry response register.
// Optional key-store command is compiled in with `define CMD_KEY_STORE_EN.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 10_334_000,
  parameter logic [7:0]  CMD_SHOOT      = 8'h41,
  parameter logic [7:0]  CMD_KEY        = 8'h42
) (
  input logic              clk,
  input logic              reset,
  uart_cmd_parser_if.slave bus
);

  localparam logic [7:0]  RspAck  = 8'h4B;  // "K"
  localparam logic [7:0]  RspErr  = 8'h45;  // "E"
  localparam logic [7:0]  RspTmo  = 8'h54;  // "T"
  localparam logic [7:0]  ArgAll  = 8'h60;  // backquote char 8'h60 revives every cat
  localparam logic [31:0] TmoLast = TIMEOUT_CYCLES - 1;

`ifdef CMD_KEY_STORE_EN
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAArg  = 3'd1,
    StAEnd  = 3'd2,
    StBIdx  = 3'd3,
    StBData = 3'd4,
    StBEnd  = 3'd5
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAArg = 2'd1,
    StAEnd = 2'd2
  } state_e;
`endif

  state_e      r_state;
  logic [31:0] r_cnt;
  logic [7:0]  r_arg;
  logic [7:0]  r_cat;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_frame_err;

  logic        w_arg_ok;
  logic        w_err;
  logic        w_ack;
  logic        w_tmo;
  logic        w_rsp_req;
  logic        w_rsp_drop;
  logic [7:0]  w_rsp_byte;
  logic [2:0]  w_cat_bit;

`ifdef CMD_KEY_STORE_EN
  logic [3:0]   r_idx;
  logic [7:0]   r_data;
  logic [127:0] r_key;
  logic [15:0]  r_mask;
  logic         r_key_valid;
  logic [6:0]   w_key_lsb;
  logic [15:0]  w_mask_set;

  // Index 0 is the MSB byte, so the byte offset is 15-idx, i.e. ~idx.
  assign w_key_lsb  = {~r_idx, 3'b000};
  assign w_mask_set = 16'h0001 << r_idx;
`endif

  assign w_arg_ok  = ((bus.rx_data >= 8'h41) && (bus.rx_data <= 8'h48)) || (bus.rx_data == ArgAll);
  // "A".."H" map to bits 0..7; the low three bits of the letter are one ahead.
  assign w_cat_bit = r_arg[2:0] - 3'd1;

  // Classify the current byte (or idle cycle) as ack, error or timeout.
  always_comb begin
    w_err = 1'b0;
    w_ack = 1'b0;
    if (bus.rx_valid) begin
      case (r_state)
        StIdle: begin
`ifdef CMD_KEY_STORE_EN
          w_err = !((bus.rx_data == CMD_SHOOT) || (bus.rx_data == CMD_KEY) ||
                    (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A));
`else
          // Key store compiled out: its mode byte is just an unknown byte.
          w_err = (bus.rx_data == CMD_KEY) ||
                  !((bus.rx_data == CMD_SHOOT) || (bus.rx_data == 8'h0D) ||
                    (bus.rx_data == 8'h0A));
`endif
        end
        StAArg: w_err = !w_arg_ok;
        StAEnd: begin
          w_ack = (bus.rx_data == CMD_SHOOT);
          w_err = (bus.rx_data != CMD_SHOOT);
        end
`ifdef CMD_KEY_STORE_EN
        StBIdx:  w_err = (bus.rx_data[7:4] != 4'd0);
        StBData: w_err = 1'b0;
        StBEnd: begin
          w_ack = (bus.rx_data == CMD_KEY);
          w_err = (bus.rx_data != CMD_KEY);
        end
`endif
        default: w_err = 1'b0;
      endcase
    end
    // A byte arriving on the timeout cycle takes priority over the timeout.
    w_tmo      = (TIMEOUT_CYCLES != 0) && (r_state != StIdle) && !bus.rx_valid &&
                 (r_cnt == TmoLast);
    w_rsp_req  = w_err || w_ack || w_tmo;
    w_rsp_byte = w_ack ? RspAck : (w_tmo ? RspTmo : RspErr);
    w_rsp_drop = w_rsp_req && r_tx_valid && !bus.tx_ready;
  end

  // Frame state machine with command commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_arg       <= 8'h00;
      r_cat       <= 8'hFF;
`ifdef CMD_KEY_STORE_EN
      r_idx       <= 4'd0;
      r_data      <= 8'h00;
      r_key       <= '0;
      r_mask      <= 16'h0000;
      r_key_valid <= 1'b0;
`endif
    end else if (w_tmo) begin
      r_state <= StIdle;
    end else if (bus.rx_valid) begin
      case (r_state)
        StIdle: begin
          if (bus.rx_data == CMD_SHOOT) begin
            r_state <= StAArg;
          end
`ifdef CMD_KEY_STORE_EN
          else if (bus.rx_data == CMD_KEY) begin
            r_state <= StBIdx;
          end
`endif
        end
        StAArg: begin
          if (w_arg_ok) begin
            r_arg   <= bus.rx_data;
            r_state <= StAEnd;
          end else begin
            r_state <= StIdle;
          end
        end
        StAEnd: begin
          r_state <= StIdle;
          if (w_ack) begin
            if (r_arg == ArgAll) begin
              r_cat <= 8'hFF;
            end else begin
              r_cat[w_cat_bit] <= 1'b0;
            end
          end
        end
`ifdef CMD_KEY_STORE_EN
        StBIdx: begin
          if (!w_err) begin
            r_idx   <= bus.rx_data[3:0];
            r_state <= StBData;
          end else begin
            r_state <= StIdle;
          end
        end
        StBData: begin
          r_data  <= bus.rx_data;
          r_state <= StBEnd;
        end
        StBEnd: begin
          r_state <= StIdle;
          if (w_ack) begin
            r_key[w_key_lsb +: 8] <= r_data;
            r_mask                <= r_mask | w_mask_set;
            // Mask only grows, so this stays set on later rewrites.
            r_key_valid           <= &(r_mask | w_mask_set);
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  // Inter-byte timeout counter; only runs while a frame is open.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 32'd0;
    end else if (bus.rx_valid || (r_state == StIdle) || w_tmo) begin
      r_cnt <= 32'd0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // Single-entry response register; a response that finds it full is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err || w_tmo || w_rsp_drop;
      if (r_tx_valid && bus.tx_ready) begin
        r_tx_valid <= 1'b0;
      end
      if (w_rsp_req && (!r_tx_valid || bus.tx_ready)) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_rsp_byte;
      end
    end
  end

  assign bus.cat_status = r_cat;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.frame_err  = r_frame_err;
`ifdef CMD_KEY_STORE_EN
  assign bus.key        = r_key;
  assign bus.key_valid  = r_key_valid;
`else
  assign bus.key        = '0;
  assign bus.key_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a vector table for shooting-flag frames
// and response handshaking, plus hand-written key-store, timeout, drop and
// reset sequences.
module tb_uart_cmd_parser;

  localparam int unsigned Tmo = 100;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rx;
    logic       rdy;
    logic [7:0] cat;
    logic       tv;
    logic [7:0] td;
    logic       fe;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One-cycle strobe, outputs sampled on the following falling edge.
  task automatic send(input logic [7:0] b, input logic rdy);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.tx_ready = rdy;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic chk_rsp(input string name, input logic tv, input logic [7:0] td,
                         input logic fe);
    chk({name, "_tv"}, 128'(bus.tx_valid), 128'(tv));
    if (tv) chk({name, "_td"}, 128'(bus.tx_data), 128'(td));
    chk({name, "_fe"}, 128'(bus.frame_err), 128'(fe));
  endtask

  initial begin
    #200_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [127:0] exp_key;
    logic [7:0]   d;
    int           n;

    n_chk        = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;

    //          rx     rdy   cat    tv    td     fe
    vecs[0]  = '{8'h41, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{8'h43, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{8'h41, 1'b0, 8'hFB, 1'b1, 8'h4B, 1'b0};
    vecs[3]  = '{8'h0D, 1'b1, 8'hFB, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{8'h41, 1'b1, 8'hFB, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{8'h48, 1'b1, 8'hFB, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{8'h41, 1'b1, 8'h7B, 1'b1, 8'h4B, 1'b0};
    vecs[7]  = '{8'h41, 1'b1, 8'h7B, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{8'h60, 1'b1, 8'h7B, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{8'h41, 1'b1, 8'hFF, 1'b1, 8'h4B, 1'b0};
    vecs[10] = '{8'h41, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{8'h49, 1'b1, 8'hFF, 1'b1, 8'h45, 1'b1};
    vecs[12] = '{8'h41, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[13] = '{8'h60, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{8'h41, 1'b1, 8'hFF, 1'b1, 8'h4B, 1'b0};
    vecs[15] = '{8'h5A, 1'b1, 8'hFF, 1'b1, 8'h45, 1'b1};
    vecs[16] = '{8'h0A, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[17] = '{8'h41, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[18] = '{8'h44, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[19] = '{8'h00, 1'b0, 8'hFF, 1'b1, 8'h45, 1'b1};
    vecs[20] = '{8'h41, 1'b0, 8'hFF, 1'b1, 8'h45, 1'b0};
    vecs[21] = '{8'h60, 1'b0, 8'hFF, 1'b1, 8'h45, 1'b0};
    vecs[22] = '{8'h41, 1'b1, 8'hFF, 1'b1, 8'h4B, 1'b0};
    vecs[23] = '{8'h0D, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_cat", 128'(bus.cat_status), 128'hFF);
    chk("rst_tv", 128'(bus.tx_valid), 128'h0);
    chk("rst_td", 128'(bus.tx_data), 128'h0);
    chk("rst_fe", 128'(bus.frame_err), 128'h0);
    chk("rst_key", bus.key, 128'h0);
    chk("rst_kv", 128'(bus.key_valid), 128'h0);

    for (int i = 0; i < 24; i++) begin
      send(vecs[i].rx, vecs[i].rdy);
      chk($sformatf("vec%0d_cat", i), 128'(bus.cat_status), 128'(vecs[i].cat));
      chk_rsp($sformatf("vec%0d", i), vecs[i].tv, vecs[i].td, vecs[i].fe);
    end

`ifdef CMD_KEY_STORE_EN
    exp_key = '0;
    for (int i = 0; i < 16; i++) begin
      d = (i == 0) ? 8'hAA : ((i == 15) ? 8'hBB : 8'(i * 17));
      exp_key[8 * (15 - i) +: 8] = d;
      send(8'h42, 1'b1);
      send(8'(i), 1'b1);
      send(d, 1'b1);
      send(8'h42, 1'b1);
      chk_rsp($sformatf("key%0d", i), 1'b1, 8'h4B, 1'b0);
      @(negedge clk);
      chk($sformatf("key%0d_kv", i), 128'(bus.key_valid), 128'(i == 15));
    end
    chk("key_msb", 128'(bus.key[127:120]), 128'hAA);
    chk("key_lsb", 128'(bus.key[7:0]), 128'hBB);
    chk("key_all", bus.key, exp_key);
    send(8'h42, 1'b1);
    send(8'h10, 1'b1);
    chk_rsp("key_idx16", 1'b1, 8'h45, 1'b1);
    send(8'h42, 1'b1);
    send(8'h03, 1'b1);
    send(8'h55, 1'b1);
    send(8'h00, 1'b1);
    chk_rsp("key_badend", 1'b1, 8'h45, 1'b1);
    chk("key_badend_key", bus.key, exp_key);
    chk("key_badend_kv", 128'(bus.key_valid), 128'h1);
`else
    send(8'h42, 1'b1);
    chk_rsp("nokey_mode", 1'b1, 8'h45, 1'b1);
    chk("nokey_key", bus.key, 128'h0);
    chk("nokey_kv", 128'(bus.key_valid), 128'h0);
`endif

    // Timeout: frame left open after the argument byte.
    send(8'h41, 1'b1);
    send(8'h42, 1'b1);
    n = 0;
    while (n < 3 * Tmo && !bus.frame_err) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", 128'(n), 128'(Tmo));
    chk("tmo_tv", 128'(bus.tx_valid), 128'h1);
    chk("tmo_td", 128'(bus.tx_data), 128'h54);
    chk("tmo_cat", 128'(bus.cat_status), 128'hFF);
    send(8'h41, 1'b1);
    send(8'h41, 1'b1);
    send(8'h41, 1'b1);
    chk("tmo_next_cat", 128'(bus.cat_status), 128'hFE);
    chk_rsp("tmo_next", 1'b1, 8'h4B, 1'b0);

    // Full response register: second ack and a later error are dropped.
    send(8'h41, 1'b0);
    send(8'h43, 1'b0);
    send(8'h41, 1'b0);
    chk("drop1_cat", 128'(bus.cat_status), 128'hFA);
    chk_rsp("drop1", 1'b1, 8'h4B, 1'b0);
    send(8'h41, 1'b0);
    send(8'h44, 1'b0);
    chk_rsp("drop2_mid", 1'b1, 8'h4B, 1'b0);
    send(8'h41, 1'b0);
    chk("drop2_cat", 128'(bus.cat_status), 128'hF2);
    chk_rsp("drop2", 1'b1, 8'h4B, 1'b1);
    send(8'h5A, 1'b0);
    chk_rsp("drop_err", 1'b1, 8'h4B, 1'b1);
    send(8'h0D, 1'b1);
    chk_rsp("drop_drain", 1'b0, 8'h00, 1'b0);

    // Reset mid-frame with a response pending.
    send(8'h5A, 1'b0);
    send(8'h41, 1'b0);
    chk_rsp("prerst", 1'b1, 8'h45, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_tv", 128'(bus.tx_valid), 128'h0);
    chk("midrst_cat", 128'(bus.cat_status), 128'hFF);
    send(8'h45, 1'b1);
    chk_rsp("midrst_arg", 1'b1, 8'h45, 1'b1);
    chk("midrst_arg_cat", 128'(bus.cat_status), 128'hFF);
    send(8'h0D, 1'b1);
    chk("midrst_end_cat", 128'(bus.cat_status), 128'hFF);
    chk_rsp("midrst_end", 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
